// File: rtl/pwm_pkg.sv
// pwm_pkg: shared mode type and period-boundary helper for pwm_multi.
package pwm_pkg;
    typedef enum logic {PWM_EDGE = 1'b0, PWM_CENTER = 1'b1} pwm_mode_t;

    // Edge mode ends at all-ones; center mode ends at 1 on the way down.
    function automatic logic pwm_last(pwm_mode_t mode, logic dir, logic [31:0] cnt, int n);
        return (mode == PWM_EDGE) ? (cnt == (32'd1 << n) - 32'd1) : (dir && cnt == 32'd1);
    endfunction
endpackage

// File: rtl/pwm_multi_if.sv
// pwm_multi_if: control, duty-write and output signals of pwm_multi.
interface pwm_multi_if
    import pwm_pkg::*;
#(
    parameter int N          = 8,
    parameter int CHANNELS   = 4,
    parameter int PRESCALE_W = 16,
    parameter int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
    logic                  ena;
    logic [PRESCALE_W-1:0] prescale;
    pwm_mode_t             mode;
    logic                  duty_wr;
    logic [CH_W-1:0]       duty_ch;
    logic [N-1:0]          duty_data;
    logic [CHANNELS-1:0]   out;
    logic                  period_start;

    modport master (output ena, prescale, mode, duty_wr, duty_ch, duty_data,
                    input out, period_start);
    modport slave  (input ena, prescale, mode, duty_wr, duty_ch, duty_data,
                    output out, period_start);
endinterface

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: one-cycle step every prescale+1 clocks while enabled.
module pwm_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  step
);
    logic [PRESCALE_W-1:0] r_pcnt;

    // >= so a prescale lowered below the running count terminates at once
    assign step = ena & (r_pcnt >= prescale);

    always_ff @(posedge clk) begin
        if (rst || !ena || step)
            r_pcnt <= '0;
        else
            r_pcnt <= r_pcnt + PRESCALE_W'(1);
    end
endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel edge/center-aligned PWM with double-buffered duties.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int N          = 8,
    parameter int CHANNELS   = 4,
    parameter int PRESCALE_W = 16
) (
    input logic        clk,
    input logic        rst,
    pwm_multi_if.slave bus
);
    logic                w_step;
    logic                w_load;
    logic                w_down;
    logic [CHANNELS-1:0] w_hit;
    logic [N-1:0]        r_cnt;
    logic                r_dir;
    pwm_mode_t           r_mode;
    logic [N-1:0]        r_shadow [CHANNELS];
    logic [N-1:0]        r_active [CHANNELS];
    logic [CHANNELS-1:0] r_out;
    logic                r_ps;

    pwm_prescaler #(.PRESCALE_W(PRESCALE_W)) u_pre (
        .clk      (clk),
        .rst      (rst),
        .ena      (bus.ena),
        .prescale (bus.prescale),
        .step     (w_step)
    );

    assign w_load = w_step & pwm_last(r_mode, r_dir, 32'(r_cnt), N);
    assign w_down = r_dir | (r_mode == PWM_CENTER && r_cnt == '1);

    always_ff @(posedge clk) begin
        if (rst || !bus.ena || w_load) begin
            r_cnt <= '0;
            r_dir <= 1'b0;
        end else if (w_step) begin
            r_cnt <= w_down ? r_cnt - N'(1) : r_cnt + N'(1);
            r_dir <= w_down;
        end
    end

    // While disabled the active set follows the shadow so a restart uses the latest values
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= '{default: '0};
            r_mode   <= PWM_EDGE;
        end else if (!bus.ena || w_load) begin
            r_active <= r_shadow;
            r_mode   <= bus.mode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_shadow <= '{default: '0};
        else if (bus.duty_wr && 32'(bus.duty_ch) < CHANNELS)
            r_shadow[bus.duty_ch] <= bus.duty_data;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign w_hit[i] = (r_active[i] == '1) | (r_cnt < r_active[i]);
    end

    always_ff @(posedge clk) begin
        r_out <= rst ? '0 : {CHANNELS{bus.ena}} & w_hit;
        r_ps  <= ~rst & w_load;
    end

    assign bus.out          = r_out;
    assign bus.period_start = r_ps;
endmodule
